// File: rtl/shift_pkg.sv
// Shared types and helpers for the one-hot-coded shifters (left and right).
// Contents:
//   DATA_W            operand/result width
//   shamt_t           6-bit binary shift amount
//   ext_t             65-bit extended operand used for overflow-free rounding
//   onehot_popcnt_gt1 true when a shift code has more than one bit set
package shift_pkg;

    localparam int unsigned DATA_W = 64;

    typedef logic [5:0]  shamt_t;
    typedef logic [64:0] ext_t;

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic onehot_popcnt_gt1(input logic [DATA_W-1:0] code);
        return (code & (code - 64'd1)) != '0;
    endfunction

endpackage

// File: rtl/srl_rnd_64b_if.sv
// Request/result bundle for the 64-bit rounding right shifter.
// Signals:
//   init_i   op valid this cycle        flush_i  drop every in-flight op
//   sign_i   arithmetic shift           round_i  add 2^(k-1) before shifting
//   shift_i  one-hot shift code         data_i   operand
//   done_o   result valid               err_o    multi-hot shift code seen
//   sticky_o OR of bits shifted out     data_o   result
// Modports: master drives requests (user side), slave is the shifter.
interface srl_rnd_64b_if;
    import shift_pkg::*;

    logic              init_i;
    logic              flush_i;
    logic              sign_i;
    logic              round_i;
    logic [DATA_W-1:0] shift_i;
    logic [DATA_W-1:0] data_i;
    logic              done_o;
    logic              err_o;
    logic              sticky_o;
    logic [DATA_W-1:0] data_o;

    modport master (
        output init_i, flush_i, sign_i, round_i, shift_i, data_i,
        input  done_o, err_o, sticky_o, data_o
    );

    modport slave (
        input  init_i, flush_i, sign_i, round_i, shift_i, data_i,
        output done_o, err_o, sticky_o, data_o
    );

endinterface

// File: rtl/prio_enc_64b.sv
// 64-bit priority encoder for one-hot shift codes.
// Ports:
//   code   in  64  shift code (ideally one-hot)
//   idx    out 6   index of the highest set bit, 0 when code is all-zero
//   multi  out 1   more than one bit of code is set
// Purely combinational.
module prio_enc_64b
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] code,
    output shamt_t            idx,
    output logic              multi
);

    // Ascending scan: the last hit wins, which is the highest set bit.
    always_comb begin
        idx = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (code[i]) begin
                idx = shamt_t'(i);
            end
        end
    end

    assign multi = onehot_popcnt_gt1(code);

endmodule

// File: rtl/srl_rnd_64b.sv
// Pipelined 64-bit right shifter with optional round-half-up and arithmetic mode.
// Computes (x + 2^(k-1)) >> k (rounding) or x >> k, k taken from a one-hot code.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset
//   bus    srl_rnd_64b_if.slave request/result bundle
// Pipeline: stage 1 decodes the code, stage 2 extends/offsets and forms sticky,
// stage 3 shifts. The result is valid after the third rising edge, counting the
// edge that samples init_i; one op per cycle, no backpressure.
module srl_rnd_64b #(
    parameter int unsigned DATA_W = 64,  // only 64 is supported
    parameter int unsigned LAT    = 3    // fixed pipeline depth
) (
    input logic         clk_i,
    input logic         rst_i,
    srl_rnd_64b_if.slave bus
);
    import shift_pkg::*;

    logic [LAT-1:0] vld_q;

    // Stage 1
    logic [DATA_W-1:0] data1_q;
    logic              sign1_q;
    logic              round1_q;
    shamt_t            k1_q;
    logic              err1_q;

    // Stage 2
    ext_t              sum2_q;
    logic              sign2_q;
    shamt_t            k2_q;
    logic              err2_q;
    logic              sticky2_q;

    // Stage 3
    logic [DATA_W-1:0] res3_q;
    logic              err3_q;
    logic              sticky3_q;

    // Combinational next-stage values
    shamt_t            k_dec;
    logic              err_dec;
    ext_t              ext_x;
    ext_t              ofs;
    ext_t              sum_d;
    logic [DATA_W-1:0] mask;
    logic              sticky_d;
    ext_t              shifted;
    logic [DATA_W-1:0] res_d;
    logic              unused_shifted_msb;

    prio_enc_64b u_enc (
        .code  (bus.shift_i),
        .idx   (k_dec),
        .multi (err_dec)
    );

    always_comb begin
        ext_x    = sign1_q ? {data1_q[DATA_W-1], data1_q} : {1'b0, data1_q};
        ofs      = '0;
        if (round1_q && (k1_q != '0)) begin
            ofs = ext_t'(1) << (k1_q - shamt_t'(1));
        end
        // 65-bit add: the extra bit absorbs the carry from the rounding offset.
        sum_d    = ext_x + ofs;
        mask     = ({{(DATA_W-1){1'b0}}, 1'b1} << k1_q) - {{(DATA_W-1){1'b0}}, 1'b1};
        sticky_d = |(data1_q & mask);
    end

    always_comb begin
        if (sign2_q) begin
            shifted = ext_t'($signed(sum2_q) >>> k2_q);
        end else begin
            shifted = sum2_q >> k2_q;
        end
        res_d = shifted[DATA_W-1:0];
    end

    // After a shift of k >= 0 the top bit is either zero or a copy of bit 63.
    assign unused_shifted_msb = shifted[DATA_W];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q     <= '0;
            data1_q   <= '0;
            sign1_q   <= 1'b0;
            round1_q  <= 1'b0;
            k1_q      <= '0;
            err1_q    <= 1'b0;
            sum2_q    <= '0;
            sign2_q   <= 1'b0;
            k2_q      <= '0;
            err2_q    <= 1'b0;
            sticky2_q <= 1'b0;
            res3_q    <= '0;
            err3_q    <= 1'b0;
            sticky3_q <= 1'b0;
        end else begin
            // Flush also swallows an init_i presented on the same edge.
            if (bus.flush_i) begin
                vld_q <= '0;
            end else begin
                vld_q <= {vld_q[LAT-2:0], bus.init_i};
            end

            if (bus.init_i && !bus.flush_i) begin
                data1_q  <= bus.data_i;
                sign1_q  <= bus.sign_i;
                round1_q <= bus.round_i;
                k1_q     <= k_dec;
                err1_q   <= err_dec;
            end

            if (vld_q[0]) begin
                sum2_q    <= sum_d;
                sign2_q   <= sign1_q;
                k2_q      <= k1_q;
                err2_q    <= err1_q;
                sticky2_q <= sticky_d;
            end

            if (vld_q[1]) begin
                res3_q    <= res_d;
                err3_q    <= err2_q;
                sticky3_q <= sticky2_q;
            end
        end
    end

    // Stage registers hold stale data when idle; outputs show zero outside done.
    assign bus.done_o   = vld_q[LAT-1];
    assign bus.data_o   = vld_q[LAT-1] ? res3_q : '0;
    assign bus.err_o    = vld_q[LAT-1] & err3_q;
    assign bus.sticky_o = vld_q[LAT-1] & sticky3_q;

endmodule

// File: tb/tb_srl_rnd_64b.sv
// Directed self-checking bench for srl_rnd_64b.
module tb_srl_rnd_64b;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    srl_rnd_64b_if bus ();

    srl_rnd_64b #(
        .DATA_W (64),
        .LAT    (3)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sg, input logic rd, input logic [63:0] sh,
                         input logic [63:0] d);
        bus.init_i  = 1'b1;
        bus.sign_i  = sg;
        bus.round_i = rd;
        bus.shift_i = sh;
        bus.data_i  = d;
    endtask

    task automatic idle;
        bus.init_i  = 1'b0;
        bus.sign_i  = 1'b0;
        bus.round_i = 1'b0;
        bus.shift_i = '0;
        bus.data_i  = '0;
    endtask

    // Issues one op into an empty pipe and samples done one edge early, on time,
    // and one edge late.
    task automatic run_op(input logic sg, input logic rd, input logic [63:0] sh,
                          input logic [63:0] d, output logic early, output logic dn,
                          output logic [63:0] q, output logic st, output logic er,
                          output logic late);
        drive(sg, rd, sh, d);
        tick;
        idle;
        tick;
        early = bus.done_o;
        tick;
        dn = bus.done_o;
        q  = bus.data_o;
        st = bus.sticky_o;
        er = bus.err_o;
        tick;
        late = bus.done_o;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.flush_i = 1'b0;
        idle;
        tick;
        tick;
        checks += 4;
        if (bus.done_o !== 1'b0) begin
            errors++; $display("FAIL reset_done got %b exp 0", bus.done_o);
        end
        if (bus.data_o !== 64'h0) begin
            errors++; $display("FAIL reset_data got %h exp 0", bus.data_o);
        end
        if (bus.sticky_o !== 1'b0) begin
            errors++; $display("FAIL reset_sticky got %b exp 0", bus.sticky_o);
        end
        if (bus.err_o !== 1'b0) begin
            errors++; $display("FAIL reset_err got %b exp 0", bus.err_o);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_logical;
        logic e, dn, st, er, l;
        logic [63:0] q;
        run_op(1'b0, 1'b0, 64'd1 << 4, 64'hF000_0000_0000_000F, e, dn, q, st, er, l);
        checks += 6;
        if (e !== 1'b0) begin errors++; $display("FAIL log_early got %b exp 0", e); end
        if (dn !== 1'b1) begin errors++; $display("FAIL log_done got %b exp 1", dn); end
        if (q !== 64'h0F00_0000_0000_0000) begin
            errors++; $display("FAIL log_data got %h exp 0f00000000000000", q);
        end
        if (st !== 1'b1) begin errors++; $display("FAIL log_sticky got %b exp 1", st); end
        if (er !== 1'b0) begin errors++; $display("FAIL log_err got %b exp 0", er); end
        if (l !== 1'b0) begin errors++; $display("FAIL log_late got %b exp 0", l); end
    endtask

    task automatic test_arith_round;
        logic e, dn, st, er, l;
        logic [63:0] q;
        run_op(1'b1, 1'b1, 64'd1 << 1, 64'hFFFF_FFFF_FFFF_FFF9, e, dn, q, st, er, l);
        checks += 3;
        if (dn !== 1'b1) begin errors++; $display("FAIL neg7_done got %b exp 1", dn); end
        if (q !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            errors++; $display("FAIL neg7_data got %h exp fffffffffffffffd", q);
        end
        if (st !== 1'b1) begin errors++; $display("FAIL neg7_sticky got %b exp 1", st); end
        run_op(1'b0, 1'b1, 64'd1 << 1, 64'd5, e, dn, q, st, er, l);
        checks += 2;
        if (q !== 64'd3) begin errors++; $display("FAIL five_data got %h exp 3", q); end
        if (st !== 1'b1) begin errors++; $display("FAIL five_sticky got %b exp 1", st); end
    endtask

    task automatic test_zero_and_overflow;
        logic e, dn, st, er, l;
        logic [63:0] q;
        // Rounding requested with k=0 must add nothing.
        run_op(1'b0, 1'b1, 64'h0, 64'h1234, e, dn, q, st, er, l);
        checks += 4;
        if (dn !== 1'b1) begin errors++; $display("FAIL zero_done got %b exp 1", dn); end
        if (q !== 64'h1234) begin errors++; $display("FAIL zero_data got %h exp 1234", q); end
        if (st !== 1'b0) begin errors++; $display("FAIL zero_sticky got %b exp 0", st); end
        if (er !== 1'b0) begin errors++; $display("FAIL zero_err got %b exp 0", er); end
        run_op(1'b0, 1'b1, 64'd1 << 1, 64'hFFFF_FFFF_FFFF_FFFF, e, dn, q, st, er, l);
        checks += 2;
        if (q !== 64'h8000_0000_0000_0000) begin
            errors++; $display("FAIL ovf_data got %h exp 8000000000000000", q);
        end
        if (st !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", st); end
    endtask

    task automatic test_multi_hot;
        logic e, dn, st, er, l;
        logic [63:0] q;
        run_op(1'b0, 1'b0, (64'd1 << 3) | (64'd1 << 8), 64'h1_0000, e, dn, q, st, er, l);
        checks += 4;
        if (dn !== 1'b1) begin errors++; $display("FAIL mh_done got %b exp 1", dn); end
        if (q !== 64'h100) begin errors++; $display("FAIL mh_data got %h exp 100", q); end
        if (er !== 1'b1) begin errors++; $display("FAIL mh_err got %b exp 1", er); end
        if (st !== 1'b0) begin errors++; $display("FAIL mh_sticky got %b exp 0", st); end
    endtask

    task automatic test_k63;
        logic e, dn, st, er, l;
        logic [63:0] q;
        run_op(1'b0, 1'b0, 64'd1 << 63, 64'h8000_0000_0000_0000, e, dn, q, st, er, l);
        checks += 2;
        if (q !== 64'd1) begin errors++; $display("FAIL k63_log_data got %h exp 1", q); end
        if (st !== 1'b0) begin errors++; $display("FAIL k63_log_sticky got %b exp 0", st); end
        run_op(1'b0, 1'b0, 64'd1 << 63, 64'hFFFF_FFFF_FFFF_FFFF, e, dn, q, st, er, l);
        checks += 2;
        if (q !== 64'd1) begin errors++; $display("FAIL k63_ones_data got %h exp 1", q); end
        if (st !== 1'b1) begin errors++; $display("FAIL k63_ones_sticky got %b exp 1", st); end
        run_op(1'b1, 1'b0, 64'd1 << 63, 64'h8000_0000_0000_0000, e, dn, q, st, er, l);
        checks += 1;
        if (q !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL k63_ari_data got %h exp ffffffffffffffff", q);
        end
        // -2^62 / 2^63 = -0.5 rounds half-up to 0.
        run_op(1'b1, 1'b1, 64'd1 << 63, 64'hC000_0000_0000_0000, e, dn, q, st, er, l);
        checks += 2;
        if (q !== 64'h0) begin errors++; $display("FAIL k63_rnd_half_data got %h exp 0", q); end
        if (st !== 1'b1) begin errors++; $display("FAIL k63_rnd_half_sticky got %b exp 1", st); end
        // -2^63 / 2^63 = -1 exactly, rounding keeps it.
        run_op(1'b1, 1'b1, 64'd1 << 63, 64'h8000_0000_0000_0000, e, dn, q, st, er, l);
        checks += 1;
        if (q !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL k63_rnd_min_data got %h exp ffffffffffffffff", q);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] exp_q [8];
        logic        exp_st [8];
        exp_q  = '{64'hFF, 64'h7F, 64'h3F, 64'h1F, 64'h0F, 64'h07, 64'h03, 64'h01};
        exp_st = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 11; i++) begin
            if (i < 8) drive(1'b0, 1'b0, 64'd1 << i, 64'hFF);
            else idle;
            tick;
            if (i >= 2 && i < 10) begin
                checks++;
                if (bus.done_o !== 1'b1 || bus.data_o !== exp_q[i-2]
                    || bus.sticky_o !== exp_st[i-2]) begin
                    errors++;
                    $display("FAIL stream_k%0d got done=%b data=%h sticky=%b exp 1 %h %b",
                             i - 2, bus.done_o, bus.data_o, bus.sticky_o,
                             exp_q[i-2], exp_st[i-2]);
                end
            end else if (i == 10) begin
                checks++;
                if (bus.done_o !== 1'b0) begin
                    errors++; $display("FAIL stream_end got %b exp 0", bus.done_o);
                end
            end
        end
    endtask

    task automatic test_flush;
        // Two ops in the pipe plus a third presented together with flush.
        drive(1'b0, 1'b0, 64'h0, 64'hAB);
        tick;
        drive(1'b0, 1'b0, 64'h0, 64'hCD);
        tick;
        drive(1'b0, 1'b0, 64'h0, 64'hEF);
        bus.flush_i = 1'b1;
        tick;
        bus.flush_i = 1'b0;
        idle;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.done_o !== 1'b0 || bus.data_o !== 64'h0) begin
                errors++;
                $display("FAIL flush_drop%0d got done=%b data=%h exp 0 0",
                         i, bus.done_o, bus.data_o);
            end
            tick;
        end
    endtask

    task automatic test_reset_mid_stream;
        logic e, dn, st, er, l;
        logic [63:0] q;
        drive(1'b0, 1'b0, 64'h3, 64'h3);
        tick;
        drive(1'b0, 1'b0, 64'h3, 64'h3);
        tick;
        idle;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if (bus.done_o !== 1'b0 || bus.data_o !== 64'h0 || bus.sticky_o !== 1'b0
            || bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got done=%b data=%h sticky=%b err=%b exp all 0",
                     bus.done_o, bus.data_o, bus.sticky_o, bus.err_o);
        end
        for (int i = 0; i < 2; i++) begin
            tick;
            checks++;
            if (bus.done_o !== 1'b0) begin
                errors++; $display("FAIL rst_drop%0d got %b exp 0", i, bus.done_o);
            end
        end
        run_op(1'b0, 1'b0, 64'd1 << 4, 64'h100, e, dn, q, st, er, l);
        checks += 3;
        if (e !== 1'b0) begin errors++; $display("FAIL rst_new_early got %b exp 0", e); end
        if (dn !== 1'b1) begin errors++; $display("FAIL rst_new_done got %b exp 1", dn); end
        if (q !== 64'h10) begin errors++; $display("FAIL rst_new_data got %h exp 10", q); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.flush_i = 1'b0;
        idle;
        test_reset;
        test_logical;
        test_arith_round;
        test_zero_and_overflow;
        test_multi_hot;
        test_k63;
        test_back_to_back;
        test_flush;
        test_reset_mid_stream;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
